// File: rtl/cb_types.sv
// Types shared between the control buffer and its commit-side consumer.
package cb_types;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        RECOVER = 2'd2
    } bcc_state_t;

    localparam int PERF_W = 32;

endpackage

// File: rtl/cpu_params.sv
// Core-wide sizing parameters shared by the backend blocks.
package cpu_params;

    localparam int ROB_IDX = 5;

endpackage

// File: rtl/branch_commit_ctrl.sv
// Commit-side control-buffer consumer: gates branch retirement on a resolved CB entry,
// pops it on commit and sequences flush/redirect recovery after a mispredict.
//
// state   | meaning
// --------+-------------------------------------------------------------
// RUN     | normal retirement; branches wait for a matching resolved CB head
// FLUSH   | one-cycle flush + frontend redirect pulse
// RECOVER | commit blocked while the backend drains, RECOVER_CYCLES cycles
module branch_commit_ctrl
    import cb_types::*;
#(
    parameter int ROB_IDX        = cpu_params::ROB_IDX,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                head_valid,
    input  logic                head_done,
    input  logic                head_is_br,
    input  logic [ROB_IDX-1:0]  head_rob_id,
    output logic                commit_ok,

    input  logic                cb_valid,
    input  logic [ROB_IDX-1:0]  cb_rob_id,
    input  logic                cb_miss_predict,
    input  logic [31:0]         cb_target_address,
    output logic                cb_dequeue,

    output logic                flush,
    output logic                redirect_valid,
    output logic [31:0]         redirect_pc,

    output logic [PERF_W-1:0]   perf_br_commits,
    output logic [PERF_W-1:0]   perf_mispredicts
);

    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    bcc_state_t state, state_next;
    logic [3:0] rcnt, rcnt_next;
    logic       match;
    logic       br_commit;

    always_comb begin
        match     = head_valid & head_done & head_is_br & cb_valid
                    & (cb_rob_id == head_rob_id);
        br_commit = (state == RUN) & match;
    end

    always_comb begin
        state_next = state;
        rcnt_next  = rcnt;
        commit_ok  = 1'b0;
        cb_dequeue = 1'b0;
        unique case (state)
            RUN: begin
                if (head_is_br) begin
                    commit_ok  = match;
                    cb_dequeue = match;
                end else begin
                    commit_ok  = head_valid & head_done;
                end
                if (match & cb_miss_predict) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                rcnt_next  = RECOVER_LOAD;
                state_next = RECOVER;
            end
            RECOVER: begin
                if (rcnt == 4'd0) begin
                    state_next = RUN;
                end else begin
                    rcnt_next = rcnt - 4'd1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            rcnt             <= 4'd0;
            redirect_pc      <= 32'd0;
            perf_br_commits  <= '0;
            perf_mispredicts <= '0;
        end else begin
            state <= state_next;
            rcnt  <= rcnt_next;
            if (br_commit) begin
                perf_br_commits <= perf_br_commits + PERF_W'(1);
            end
            if (br_commit & cb_miss_predict) begin
                perf_mispredicts <= perf_mispredicts + PERF_W'(1);
                redirect_pc      <= cb_target_address;
            end
        end
    end

    // Pulses come straight off the state register so the frontend sees no input-to-output path.
    always_comb begin
        flush          = (state == FLUSH);
        redirect_valid = (state == FLUSH);
    end

endmodule

// File: tb/tb_branch_commit_ctrl.sv
// Self-checking bench for branch_commit_ctrl: vector table, directed recovery sequences
// and a randomized run against a cycle-indexed reference model.
module tb_branch_commit_ctrl;

    localparam int RIDX = cpu_params::ROB_IDX;
    localparam int RC   = 2;

    logic            clk;
    logic            rst;
    logic            head_valid, head_done, head_is_br;
    logic [RIDX-1:0] head_rob_id;
    logic            commit_ok;
    logic            cb_valid;
    logic [RIDX-1:0] cb_rob_id;
    logic            cb_miss_predict;
    logic [31:0]     cb_target_address;
    logic            cb_dequeue;
    logic            flush, redirect_valid;
    logic [31:0]     redirect_pc;
    logic [31:0]     perf_br_commits, perf_mispredicts;

    branch_commit_ctrl #(.ROB_IDX(RIDX), .RECOVER_CYCLES(RC)) dut (
        .clk               (clk),
        .rst               (rst),
        .head_valid        (head_valid),
        .head_done         (head_done),
        .head_is_br        (head_is_br),
        .head_rob_id       (head_rob_id),
        .commit_ok         (commit_ok),
        .cb_valid          (cb_valid),
        .cb_rob_id         (cb_rob_id),
        .cb_miss_predict   (cb_miss_predict),
        .cb_target_address (cb_target_address),
        .cb_dequeue        (cb_dequeue),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .perf_br_commits   (perf_br_commits),
        .perf_mispredicts  (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    typedef struct {
        logic hv, hd, hb;
        int   hid;
        logic cv;
        int   cid;
        logic exp_commit, exp_deq;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic hv, input logic hd, input logic hb, input int hid,
                         input logic cv, input int cid, input logic miss, input logic [31:0] tgt);
        head_valid        = hv;
        head_done         = hd;
        head_is_br        = hb;
        head_rob_id       = RIDX'(hid);
        cb_valid          = cv;
        cb_rob_id         = RIDX'(cid);
        cb_miss_predict   = miss;
        cb_target_address = tgt;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0);
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // reference model state for the random run
    int          cyc, resume_cyc, flush_cyc;
    logic [31:0] m_brc, m_mp, m_pc;

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 32'd0);

        tbl[0]  = '{1, 1, 0,  0, 0,  0, 1, 0};
        tbl[1]  = '{1, 0, 0,  0, 0,  0, 0, 0};
        tbl[2]  = '{0, 1, 0,  0, 0,  0, 0, 0};
        tbl[3]  = '{1, 1, 1,  5, 1,  5, 1, 1};
        tbl[4]  = '{1, 1, 1,  5, 1,  4, 0, 0};
        tbl[5]  = '{1, 1, 1,  5, 0,  5, 0, 0};
        tbl[6]  = '{1, 0, 1,  5, 1,  5, 0, 0};
        tbl[7]  = '{0, 1, 1,  5, 1,  5, 0, 0};
        tbl[8]  = '{1, 1, 1, 31, 1, 31, 1, 1};
        tbl[9]  = '{1, 1, 1, 16, 1,  0, 0, 0};
        tbl[10] = '{1, 1, 1,  0, 1,  0, 1, 1};
        tbl[11] = '{1, 1, 0,  7, 1,  7, 1, 0};

        // reset state
        step();
        step();
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_redirect_valid", {31'd0, redirect_valid}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        chk("rst_perf_br", perf_br_commits, 32'd0);
        chk("rst_perf_mp", perf_mispredicts, 32'd0);
        rst = 1'b0;

        // vector table
        begin
            int exp_brc = 0;
            for (int i = 0; i < 12; i++) begin
                drive(tbl[i].hv, tbl[i].hd, tbl[i].hb, tbl[i].hid,
                      tbl[i].cv, tbl[i].cid, 1'b0, 32'hdead_beef);
                #2;
                chk($sformatf("tbl%0d_commit_ok", i), {31'd0, commit_ok}, {31'd0, tbl[i].exp_commit});
                chk($sformatf("tbl%0d_cb_dequeue", i), {31'd0, cb_dequeue}, {31'd0, tbl[i].exp_deq});
                step();
                if (tbl[i].exp_deq) exp_brc++;
                chk($sformatf("tbl%0d_perf_br", i), perf_br_commits, 32'(exp_brc));
                chk($sformatf("tbl%0d_flush", i), {31'd0, flush}, 32'd0);
            end
            chk("tbl_perf_mp", perf_mispredicts, 32'd0);
        end

        // stall on id mismatch / unresolved CB, commit on first match
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) drive(1, 1, 1, 5, 1, 4, 0, 32'd0);
            else            drive(1, 1, 1, 5, 0, 5, 0, 32'd0);
            #2;
            chk("stall_commit_ok", {31'd0, commit_ok}, 32'd0);
            chk("stall_cb_dequeue", {31'd0, cb_dequeue}, 32'd0);
            step();
        end
        chk("stall_perf_br", perf_br_commits, 32'd0);
        drive(1, 1, 1, 5, 1, 5, 0, 32'd0);
        #2;
        chk("match_commit_ok", {31'd0, commit_ok}, 32'd1);
        chk("match_cb_dequeue", {31'd0, cb_dequeue}, 32'd1);
        step();
        chk("match_perf_br", perf_br_commits, 32'd1);
        chk("match_no_flush", {31'd0, flush}, 32'd0);

        // mispredict recovery timeline
        do_reset();
        drive(1, 1, 1, 5, 1, 5, 1, 32'h1000_0040);
        #2;
        chk("mp_T_commit_ok", {31'd0, commit_ok}, 32'd1);
        chk("mp_T_flush", {31'd0, flush}, 32'd0);
        step();
        drive(1, 1, 0, 6, 1, 6, 0, 32'd0);
        #2;
        chk("mp_T1_flush", {31'd0, flush}, 32'd1);
        chk("mp_T1_redirect_valid", {31'd0, redirect_valid}, 32'd1);
        chk("mp_T1_redirect_pc", redirect_pc, 32'h1000_0040);
        chk("mp_T1_commit_ok", {31'd0, commit_ok}, 32'd0);
        chk("mp_perf_mp", perf_mispredicts, 32'd1);
        chk("mp_perf_br", perf_br_commits, 32'd1);
        for (int k = 2; k < 2 + RC; k++) begin
            step();
            #2;
            chk($sformatf("mp_T%0d_commit_ok", k), {31'd0, commit_ok}, 32'd0);
            chk($sformatf("mp_T%0d_cb_dequeue", k), {31'd0, cb_dequeue}, 32'd0);
            chk($sformatf("mp_T%0d_flush", k), {31'd0, flush}, 32'd0);
        end
        step();
        #2;
        chk("mp_resume_commit_ok", {31'd0, commit_ok}, 32'd1);
        step();

        // reset in the middle of recovery
        do_reset();
        drive(1, 1, 1, 5, 1, 5, 1, 32'h1000_0040);
        step();
        drive(1, 1, 0, 6, 0, 0, 0, 32'd0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("rstrec_commit_ok", {31'd0, commit_ok}, 32'd1);
        chk("rstrec_perf_br", perf_br_commits, 32'd0);
        chk("rstrec_perf_mp", perf_mispredicts, 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("rstrec_no_flush", {31'd0, flush}, 32'd0);
            step();
            #2;
        end

        // four back-to-back correct branches
        begin
            int deq_pulses = 0;
            for (int k = 1; k <= 4; k++) begin
                drive(1, 1, 1, k, 1, k, 0, 32'd0);
                #2;
                if (cb_dequeue) deq_pulses++;
                step();
            end
            chk("b2b_dequeues", 32'(deq_pulses), 32'd4);
            chk("b2b_perf_br", perf_br_commits, 32'd4);
            chk("b2b_perf_mp", perf_mispredicts, 32'd0);
        end

        // randomized run against the cycle-indexed model
        do_reset();
        cyc = 0; resume_cyc = 0; flush_cyc = -1;
        m_brc = 0; m_mp = 0; m_pc = 0;
        for (int n = 0; n < 3000; n++) begin
            logic hv, hd, hb, cv, miss, r, in_run, is_match, ex_commit, ex_deq, ex_flush;
            int hid, cid;
            logic [31:0] tgt;
            hv   = ($urandom_range(0, 7) != 0);
            hd   = ($urandom_range(0, 3) != 0);
            hb   = $urandom_range(0, 1) == 1;
            cv   = ($urandom_range(0, 3) != 0);
            hid  = $urandom_range(0, 3);
            cid  = $urandom_range(0, 3);
            miss = ($urandom_range(0, 3) == 0);
            tgt  = $urandom;
            r    = ($urandom_range(0, 63) == 0);
            drive(hv, hd, hb, hid, cv, cid, miss, tgt);
            rst = r;
            #2;
            in_run    = (cyc >= resume_cyc);
            is_match  = hv && hd && hb && cv && (hid == cid);
            ex_commit = in_run && (hb ? is_match : (hv && hd));
            ex_deq    = in_run && hb && is_match;
            ex_flush  = (cyc == flush_cyc);
            if (!r) begin
                chk("rnd_commit_ok", {31'd0, commit_ok}, {31'd0, ex_commit});
                chk("rnd_cb_dequeue", {31'd0, cb_dequeue}, {31'd0, ex_deq});
                chk("rnd_flush", {31'd0, flush}, {31'd0, ex_flush});
                chk("rnd_redirect_valid", {31'd0, redirect_valid}, {31'd0, ex_flush});
                if (ex_flush) chk("rnd_redirect_pc", redirect_pc, m_pc);
            end
            step();
            if (r) begin
                m_brc = 0; m_mp = 0; m_pc = 0;
                resume_cyc = cyc + 1;
                flush_cyc = -1;
            end else if (in_run && is_match) begin
                m_brc = m_brc + 1;
                if (miss) begin
                    m_mp = m_mp + 1;
                    m_pc = tgt;
                    flush_cyc = cyc + 1;
                    resume_cyc = cyc + 2 + RC;
                end
            end
            chk("rnd_perf_br", perf_br_commits, m_brc);
            chk("rnd_perf_mp", perf_mispredicts, m_mp);
            cyc++;
        end
        rst = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/branch_commit_ctrl.md
# branch_commit_ctrl

Commit-side consumer of the control buffer, sitting between the ROB head and the control buffer's `cb_rob_itf` end. It gates retirement of control-flow uops until the matching control-buffer entry is resolved. It pops that entry on commit. On a mispredict it runs a flush/redirect recovery sequence for the backend and the frontend. It also keeps branch and mispredict performance counters.

## Interface
Parameters:
- `ROB_IDX`, default from `cpu_params`: ROB index width.
- `RECOVER_CYCLES`, default 2: cycles commit stays blocked after the flush pulse (range 1–15).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `head_valid`  in  1  ROB head entry is occupied.
- `head_done`  in  1  ROB head has finished executing.
- `head_is_br`  in  1  ROB head is a control-flow uop (branch or jump).
- `head_rob_id`  in  ROB_IDX  index of the ROB head.
- `commit_ok`  out  1  ROB may retire its head this cycle.
- `cb_valid`  in  1  control-buffer head entry exists and is resolved.
- `cb_rob_id`  in  ROB_IDX  rob_id of the control-buffer head.
- `cb_miss_predict`  in  1  control-buffer head mispredicted.
- `cb_target_address`  in  32  correct next PC for the control-buffer head.
- `cb_dequeue`  out  1  pop the control-buffer head.
- `flush`  out  1  one-cycle pulse that clears the ROB, RS, CB and rename state.
- `redirect_valid`  out  1  one-cycle pulse to the frontend, coincident with `flush`.
- `redirect_pc`  out  32  fetch restart PC; valid only when `redirect_valid` is 1.
- `perf_br_commits`  out  32  count of committed control uops.
- `perf_mispredicts`  out  32  count of committed mispredicted control uops.

## Operation
States are RUN, FLUSH and RECOVER.

RUN:
- Non-branch head: `commit_ok = head_valid & head_done`. `cb_dequeue` is 0.
- Branch head: define `match = head_valid & head_done & head_is_br & cb_valid & (cb_rob_id == head_rob_id)`.
  - `commit_ok = match` and `cb_dequeue = match`, both combinational in the same cycle.
- Branch head with no match, whether from `cb_valid` = 0 or an id mismatch: stall. `commit_ok` and `cb_dequeue` are both 0.
- On `match`, `perf_br_commits` increments.
- On `match & cb_miss_predict`:
  - `perf_mispredicts` increments.
  - `cb_target_address` is latched into `redirect_pc`.
  - Next state is FLUSH.
- Otherwise the block stays in RUN.

FLUSH (exactly 1 cycle):
- `flush = 1`, `redirect_valid = 1`.
- `commit_ok = 0`, `cb_dequeue = 0`.
- Loads the recovery counter with `RECOVER_CYCLES - 1`. Next state is RECOVER.

RECOVER:
- `commit_ok = 0`, `cb_dequeue = 0`, `flush = 0`, `redirect_valid = 0`.
- The counter decrements each cycle. When the counter is 0 in RECOVER, next state is RUN.
- All `head_*` and `cb_*` inputs are ignored in FLUSH and RECOVER.

Arithmetic rules:
- Counters are 32-bit and wrap modulo 2^32.
- The recovery counter is 4 bits.
- The rob_id compare is a full `ROB_IDX`-bit equality compare.

## Timing
- Reset values: state RUN, `flush` 0, `redirect_valid` 0, `redirect_pc` 0, both perf counters 0, recovery counter 0.
- `commit_ok` and `cb_dequeue` are combinational from the inputs plus state. They are 0 whenever state is not RUN.
- `flush`, `redirect_valid` and `redirect_pc` are decoded from registered state and registered data, with no combinational path from the inputs.
- Mispredict sequence, with the mispredicted branch committing in cycle T:
  - T+1: `flush` and `redirect_valid` are high.
  - T+2 .. T+1+RECOVER_CYCLES: RECOVER.
  - T+2+RECOVER_CYCLES: first cycle in which `commit_ok` can be 1 again.
- Correctly predicted branches cost zero extra cycles. Back-to-back branch commits are allowed, one per cycle.
- At most one commit per cycle.
- `rst` asserted in any state, including mid-FLUSH or mid-RECOVER, returns the block to RUN next cycle. No flush pulse is produced on the reset cycle or the cycle after.
- `rst` has priority over every other event. Counter increments in the reset cycle are discarded.

## Structure
- Shared package `cb_types` holds:
  - the state enum `bcc_state_t` with values RUN, FLUSH, RECOVER;
  - the constant `PERF_W = 32`.
- `ROB_IDX` comes from `cpu_params`.
- Single module, no sub-modules. The two perf counters are plain registers inside the block.

## Test plan
- Reset, then a non-branch head with `head_valid = 1`, `head_done = 1` → `commit_ok = 1`, `cb_dequeue = 0`, counters stay 0.
- Branch head with rob_id 5, `cb_valid = 1`, `cb_rob_id = 5`, `cb_miss_predict = 0` → same-cycle `commit_ok = 1`, `cb_dequeue = 1`, `perf_br_commits = 1`, no flush.
- Branch head with rob_id 5 while `cb_rob_id = 4` or `cb_valid = 0` → `commit_ok = 0`, `cb_dequeue = 0` for as long as that holds. Commit occurs in the first cycle a match appears.
- Mispredicted branch in cycle T with target 0x1000_0040, `RECOVER_CYCLES = 2`:
  - T+1: `flush = 1`, `redirect_valid = 1`, `redirect_pc = 0x1000_0040`.
  - T+2 and T+3: `commit_ok = 0` with a valid, done head present.
  - T+4: `commit_ok = 1`.
  - `perf_mispredicts = 1`.
- `rst` pulsed in T+2 of the previous scenario → state RUN at T+3, counters 0, no further `flush`.
- Four consecutive correct branches committing on back-to-back cycles → four `cb_dequeue` pulses, `perf_br_commits = 4`.
